line_writeback: RTL and testbench

Cache victim-line writeback engine: the read-side client of the cache data RAM. On a writeback request it reads the `WORD_NUM` words of one cache line out of the data RAM (one-cycle registered read) and streams them to the memory side over a valid/ready channel, with a full byte address per word and a last-word marker. It sits between the cache controller (request side), the data RAM read port, and the memory write interface.

---
 rtl/line_writeback.sv | 107 ++++++++++
 tb/tb_line_writeback.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/line_writeback.sv
// Cache victim-line writeback: reads one line from the data RAM and streams it to memory.
// Optional LINE_WB_FULL_RATE_EN selects 1 word/cycle lookahead addressing; default is 1 word/2 cycles.
module line_writeback #(
  parameter int DATA_WIDTH        = 32,
  parameter int WORD_NUM          = 4,
  parameter int INDEX_WIDTH       = 7,
  parameter int WORD_OFFSET_WIDTH = 2,
  parameter int TAG_WIDTH         = 21,
  parameter int AW                = TAG_WIDTH + INDEX_WIDTH + WORD_OFFSET_WIDTH + 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [INDEX_WIDTH-1:0]       req_index,
  input  logic [TAG_WIDTH-1:0]         req_tag,
  output logic [INDEX_WIDTH-1:0]       ram_index,
  output logic [WORD_OFFSET_WIDTH-1:0] ram_offset,
  input  logic [DATA_WIDTH-1:0]        ram_rdata,
  output logic                         mem_valid,
  input  logic                         mem_ready,
  output logic [AW-1:0]                mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_data,
  output logic                         mem_last,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STREAM} state_t;

  state_t                         r_state;
  logic [TAG_WIDTH-1:0]           r_tag;
  logic [INDEX_WIDTH-1:0]         r_index;
  logic [WORD_OFFSET_WIDTH-1:0]   r_wp;
  logic                           r_mem_valid;
  logic                           r_done;

  logic w_hs;
  logic w_last;

  assign w_hs   = r_mem_valid && mem_ready;
  assign w_last = (r_wp == WORD_OFFSET_WIDTH'(WORD_NUM - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tag       <= '0;
      r_index     <= '0;
      r_wp        <= '0;
      r_mem_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_tag   <= req_tag;
            r_index <= req_index;
            r_wp    <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state     <= S_STREAM;
          r_mem_valid <= 1'b1;
        end
        S_STREAM: begin
          if (w_hs) begin
            if (w_last) begin
              r_state     <= S_IDLE;
              r_mem_valid <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_wp <= r_wp + 1'b1;
`ifndef LINE_WB_FULL_RATE_EN
              // Re-issue the RAM read for the next word; valid drops for one cycle.
              r_state     <= S_ISSUE;
              r_mem_valid <= 1'b0;
`endif
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_mem_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef LINE_WB_FULL_RATE_EN
  // Look ahead one word on a non-last handshake so the next word lands right after it.
  assign ram_offset = (w_hs && !w_last) ? r_wp + 1'b1 : r_wp;
`else
  assign ram_offset = r_wp;
`endif

  assign ram_index = r_index;
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign mem_valid = r_mem_valid;
  assign mem_data  = ram_rdata;
  assign mem_last  = r_mem_valid && w_last;
  assign mem_addr  = {r_tag, r_index, r_wp, 2'b00};

endmodule

// File: tb/tb_line_writeback.sv
// Directed bench for line_writeback: RAM model with one-cycle registered read, per-word checks,
// stall, held request, mid-line reset and back-to-back lines.
module tb_line_writeback;
  localparam int DW = 32, WN = 4, IW = 7, OW = 2, TW = 21, AW = TW + IW + OW + 2;
`ifdef LINE_WB_FULL_RATE_EN
  localparam int LAST_DONE = 6;
`else
  localparam int LAST_DONE = 9;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [IW-1:0] req_index = '0;
  logic [TW-1:0] req_tag = '0;
  logic [IW-1:0] ram_index;
  logic [OW-1:0] ram_offset;
  logic [DW-1:0] ram_rdata = '0;
  logic          mem_valid;
  logic          mem_ready = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_last;
  logic          busy;
  logic          done;

  line_writeback dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index), .req_tag(req_tag),
    .ram_index(ram_index), .ram_offset(ram_offset), .ram_rdata(ram_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_last(mem_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:(1<<IW)-1][0:WN-1];
  always @(posedge clk) ram_rdata <= ram[ram_index][ram_offset];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One line; cycle 0 is the accept cycle (already in progress when pre_acc is set).
  task automatic run_line(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                          input int stall_w, input int stall_n,
                          input bit hold, input logic [IW-1:0] h_idx, input logic [TW-1:0] h_tag,
                          input bit pre_acc);
    int k = 0;
    int left = stall_n;
    int first_v = -1;
    int nval = 0;
    bit got_done = 1'b0;
    logic [OW-1:0] kw;
    logic [AW-1:0] ea;
    if (!pre_acc) begin
      @(negedge clk);
      req_valid = 1'b1; req_index = idx; req_tag = tag; mem_ready = 1'b1;
      #1 chk("accept_ready", req_ready, 1);
    end
    for (int t = 1; t <= 40 && !got_done; t++) begin
      @(negedge clk);
      if (hold) begin
        req_valid = 1'b1; req_index = h_idx; req_tag = h_tag;
      end else req_valid = 1'b0;
      mem_ready = 1'b1;
      if (mem_valid && k == stall_w && left > 0) begin
        mem_ready = 1'b0;
        left--;
      end
      #1;
      if (done) begin
        got_done = 1'b1;
        chk("done_cycle", t, LAST_DONE + stall_n);
        chk("words", k, WN);
        chk("valid_cycles", nval, WN + stall_n);
        chk("first_valid", first_v, 2);
        chk("done_ready", req_ready, 1);
        chk("done_busy", busy, 0);
      end else begin
        chk("busy", busy, 1);
        if (hold) chk("hold_ignored", req_ready, 0);
        if (mem_valid) begin
          if (first_v < 0) first_v = t;
          nval++;
          kw = OW'(k);
          ea = {tag, idx, kw, 2'b00};
          chk("addr", mem_addr, ea);
          chk("data", mem_data, ram[idx][kw]);
          chk("last", mem_last, (k == WN - 1));
          if (mem_ready) k++;
        end
      end
    end
    if (!got_done) chk("timeout", 0, 1);
  endtask

  initial begin
    int k;
    int dn;
    bit seen;
    for (int i = 0; i < (1 << IW); i++)
      for (int w = 0; w < WN; w++)
        ram[i][w] = {8'hA5, 8'(i), 8'h3C, 8'(w)};
    ram[5][0] = 32'h11; ram[5][1] = 32'h22; ram[5][2] = 32'h33; ram[5][3] = 32'h44;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_last", mem_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ram_index", ram_index, 0);
    chk("rst_ram_offset", ram_offset, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_ready", req_ready, 1);
    chk("idle_valid", mem_valid, 0);

    run_line(7'h05, 21'h1ABCD, -1, 0, 1'b0, '0, '0, 1'b0);
    run_line(7'h05, 21'h1ABCD, 1, 3, 1'b0, '0, '0, 1'b0);
    run_line(7'h05, 21'h1ABCD, -1, 0, 1'b1, 7'h33, 21'h0BEEF, 1'b0);
    run_line(7'h33, 21'h0BEEF, -1, 0, 1'b0, '0, '0, 1'b1);

    // Reset while word 2 is waiting on the memory side.
    @(negedge clk);
    req_valid = 1'b1; req_index = 7'h05; req_tag = 21'h1ABCD; mem_ready = 1'b1;
    k = 0;
    seen = 1'b0;
    for (int t = 1; t <= 40 && !seen; t++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_ready = 1'b1;
      if (mem_valid && k == 2) begin
        mem_ready = 1'b0;
        rst = 1'b1;
        seen = 1'b1;
      end else if (mem_valid) k++;
    end
    if (!seen) chk("rst_timeout", 0, 1);
    @(negedge clk);
    #1;
    chk("midrst_valid", mem_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", req_ready, 1);
    rst = 1'b0;
    mem_ready = 1'b1;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (done || mem_valid) dn++;
    end
    chk("midrst_quiet", dn, 0);
    run_line(7'h05, 21'h1ABCD, -1, 0, 1'b0, '0, '0, 1'b0);

    run_line(7'h7F, 21'h1FFFF, -1, 0, 1'b1, 7'h00, 21'h00001, 1'b0);
    run_line(7'h00, 21'h00001, -1, 0, 1'b0, '0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
